// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - three-way DRAM port arbiter (video, CPU, DMA) over a 4-phase cycle.
// Define DRAM_ARB_STARVE_GUARD_EN to enable the DMA starvation counter and promotion.
module dram_arbiter #(
    parameter int STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        c0,
    input  logic        c1,
    input  logic        c2,
    input  logic        c3,
    input  logic        vid_req,
    input  logic [20:0] vid_addr,
    output logic        vid_next,
    output logic        vid_strobe,
    input  logic        cpu_req,
    input  logic        cpu_rnw,
    input  logic [20:0] cpu_addr,
    input  logic        cpu_wrbsel,
    input  logic [7:0]  cpu_wrdata,
    output logic        cpu_next,
    output logic        cpu_strobe,
    output logic        cpu_latch,
    output logic [15:0] cpu_rddata,
    input  logic        dma_req,
    input  logic        dma_rnw,
    input  logic [20:0] dma_addr,
    input  logic [15:0] dma_wrdata,
    output logic        dma_next,
    output logic        dma_strobe,
    output logic        dram_req,
    output logic        dram_rnw,
    output logic [20:0] dram_addr,
    output logic [1:0]  dram_bsel,
    output logic [15:0] dram_wrdata,
    input  logic [15:0] dram_rddata
);

    typedef enum logic [1:0] {OWN_IDLE, OWN_VID, OWN_CPU, OWN_DMA} own_t;

    own_t own, own_nxt, win;
    logic dma_urgent;

`ifdef DRAM_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIM + 1);
    logic [CW-1:0] starve_cnt;

    assign dma_urgent = (starve_cnt == CW'(STARVE_LIM));

    // Counter saturates at the limit so DMA stays urgent while video keeps winning.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (c3) begin
            if (dma_req && (win != OWN_DMA)) begin
                if (!dma_urgent) starve_cnt <= starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end
        end
    end
`else
    logic unused_lim;
    assign unused_lim = ^32'(STARVE_LIM);
    assign dma_urgent = 1'b0;
`endif

    always_comb begin
        win = OWN_IDLE;
        if (vid_req)                     win = OWN_VID;
        else if (dma_urgent && dma_req)  win = OWN_DMA;
        else if (cpu_req)                win = OWN_CPU;
        else if (dma_req)                win = OWN_DMA;
    end

    always_comb begin
        own_nxt = own;
        if (c3) own_nxt = win;
    end

    assign vid_next = vid_req;
    assign cpu_next = !vid_req && !(dma_urgent && dma_req);
    assign dma_next = (win == OWN_DMA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) own <= OWN_IDLE;
        else        own <= own_nxt;
    end

    // DRAM command is latched once at c3 and held for the whole owned cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dram_req    <= 1'b0;
            dram_rnw    <= 1'b1;
            dram_addr   <= '0;
            dram_bsel   <= 2'b00;
            dram_wrdata <= '0;
        end else if (c3) begin
            dram_req  <= (win != OWN_IDLE);
            dram_rnw  <= 1'b1;
            dram_bsel <= 2'b11;
            case (win)
                OWN_VID: dram_addr <= vid_addr;
                OWN_CPU: begin
                    dram_addr <= cpu_addr;
                    dram_rnw  <= cpu_rnw;
                    if (!cpu_rnw) begin
                        dram_bsel   <= cpu_wrbsel ? 2'b10 : 2'b01;
                        dram_wrdata <= {cpu_wrdata, cpu_wrdata};
                    end
                end
                OWN_DMA: begin
                    dram_addr   <= dma_addr;
                    dram_rnw    <= dma_rnw;
                    dram_wrdata <= dma_wrdata;
                end
                default: ;
            endcase
        end
    end

    assign vid_strobe = c2 && (own == OWN_VID);
    assign cpu_strobe = c2 && (own == OWN_CPU) && dram_rnw;
    assign dma_strobe = c2 && (own == OWN_DMA);

    // Latch stays high across back-to-back CPU reads since each strobe re-arms it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_latch  <= 1'b0;
            cpu_rddata <= '0;
        end else if (cpu_strobe) begin
            cpu_latch  <= 1'b1;
            cpu_rddata <= dram_rddata;
        end else if (c2) begin
            cpu_latch  <= 1'b0;
        end
    end

    logic unused_phase;
    assign unused_phase = c0 ^ c1;

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - self-checking bench for dram_arbiter.
module tb_dram_arbiter;
    localparam int LIM = 4;
    localparam logic [1:0] O_IDLE = 2'd0, O_VID = 2'd1, O_CPU = 2'd2, O_DMA = 2'd3;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        c0, c1, c2, c3;
    logic        vid_req = 0, vid_next, vid_strobe;
    logic [20:0] vid_addr = 0;
    logic        cpu_req = 0, cpu_rnw = 1, cpu_wrbsel = 0, cpu_next, cpu_strobe, cpu_latch;
    logic [20:0] cpu_addr = 0;
    logic [7:0]  cpu_wrdata = 0;
    logic [15:0] cpu_rddata;
    logic        dma_req = 0, dma_rnw = 1, dma_next, dma_strobe;
    logic [20:0] dma_addr = 0;
    logic [15:0] dma_wrdata = 0;
    logic        dram_req, dram_rnw;
    logic [20:0] dram_addr;
    logic [1:0]  dram_bsel;
    logic [15:0] dram_wrdata, dram_rddata = 0;

    dram_arbiter #(.STARVE_LIM(LIM)) dut (
        .clk(clk), .rst_n(rst_n), .c0(c0), .c1(c1), .c2(c2), .c3(c3),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_next(vid_next), .vid_strobe(vid_strobe),
        .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_wrbsel(cpu_wrbsel),
        .cpu_wrdata(cpu_wrdata), .cpu_next(cpu_next), .cpu_strobe(cpu_strobe),
        .cpu_latch(cpu_latch), .cpu_rddata(cpu_rddata),
        .dma_req(dma_req), .dma_rnw(dma_rnw), .dma_addr(dma_addr), .dma_wrdata(dma_wrdata),
        .dma_next(dma_next), .dma_strobe(dma_strobe),
        .dram_req(dram_req), .dram_rnw(dram_rnw), .dram_addr(dram_addr), .dram_bsel(dram_bsel),
        .dram_wrdata(dram_wrdata), .dram_rddata(dram_rddata)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int losses = 0;
    int ph = 0;
    bit guard_on = 1'b0;
    bit prev_rd = 1'b0;
    logic [15:0] rd_hold = 16'h0;

    typedef struct {
        logic v, c, crnw, cbs;
        logic [7:0] cb;
        logic [20:0] caddr;
        logic d, drnw;
        logic [1:0] eown;
        logic enext;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_ph();
        c0 = (ph == 0); c1 = (ph == 1); c2 = (ph == 2); c3 = (ph == 3);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ph = (ph + 1) % 4;
        set_ph();
    endtask

    task automatic to_c3();
        for (int i = 0; i < 4 && ph != 3; i++) step();
    endtask

    task automatic scramble();
        vid_req = 1'($urandom); cpu_req = 1'($urandom); dma_req = 1'($urandom);
        cpu_rnw = 1'($urandom); dma_rnw = 1'($urandom); cpu_wrbsel = 1'($urandom);
        cpu_wrdata = 8'($urandom); dma_wrdata = 16'($urandom);
        vid_addr = 21'($urandom); cpu_addr = 21'($urandom); dma_addr = 21'($urandom);
        dram_rddata = 16'($urandom);
    endtask

    // One full DRAM cycle: drive at c3, check command after c3, strobes at c2, data at next c3.
    task automatic do_cycle(input logic v, input logic c, input logic crnw, input logic cbs,
                            input logic [7:0] cb, input logic [20:0] caddr, input logic d,
                            input logic drnw, input logic [1:0] eown, input logic enext,
                            input logic [15:0] rdv);
        logic [20:0] va, da, eaddr;
        logic [15:0] dw, ewd;
        logic [1:0]  ebs;
        logic        ernw, ewr, erd;
        to_c3();
        chk("latch_pre", cpu_latch, prev_rd);
        va = 21'($urandom); da = 21'($urandom); dw = 16'($urandom);
        vid_req = v; vid_addr = va;
        cpu_req = c; cpu_rnw = crnw; cpu_wrbsel = cbs; cpu_wrdata = cb; cpu_addr = caddr;
        dma_req = d; dma_rnw = drnw; dma_addr = da; dma_wrdata = dw;
        #1;
        chk("vid_next", vid_next, eown == O_VID);
        chk("cpu_next", cpu_next, enext);
        chk("dma_next", dma_next, eown == O_DMA);
        step();
        ernw = 1'b1; ebs = 2'b11; eaddr = va; ewd = 16'h0; ewr = 1'b0;
        if (eown == O_CPU) begin
            eaddr = caddr; ernw = crnw;
            if (!crnw) begin ebs = cbs ? 2'b10 : 2'b01; ewd = {cb, cb}; ewr = 1'b1; end
        end else if (eown == O_DMA) begin
            eaddr = da; ernw = drnw; ewd = dw; ewr = !drnw;
        end
        erd = (eown == O_CPU) && crnw;
        chk("dram_req", dram_req, eown != O_IDLE);
        if (eown != O_IDLE) begin
            chk("dram_rnw", dram_rnw, ernw);
            chk("dram_addr", dram_addr, eaddr);
            chk("dram_bsel", dram_bsel, ebs);
            if (ewr) chk("dram_wrdata", dram_wrdata, ewd);
        end
        scramble();
        chk("latch_c0", cpu_latch, prev_rd);
        step();
        chk("latch_c1", cpu_latch, prev_rd);
        step();
        dram_rddata = rdv;
        #1;
        chk("vid_strobe", vid_strobe, eown == O_VID);
        chk("cpu_strobe", cpu_strobe, erd);
        chk("dma_strobe", dma_strobe, eown == O_DMA);
        chk("latch_c2", cpu_latch, prev_rd);
        step();
        if (erd) rd_hold = rdv;
        chk("cpu_rddata", cpu_rddata, rd_hold);
        chk("latch_post", cpu_latch, erd);
        prev_rd = erd;
        if (d && eown != O_DMA) losses = (losses < LIM) ? losses + 1 : LIM;
        else losses = 0;
    endtask

    initial begin
        logic v, c, d, urg;
        logic [1:0] eo;
`ifdef DRAM_ARB_STARVE_GUARD_EN
        guard_on = 1'b1;
`endif
        tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 21'h012345, 1'b0, 1'b1, O_CPU,  1'b1};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 21'h012346, 1'b0, 1'b1, O_CPU,  1'b1};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 21'h000400, 1'b0, 1'b1, O_CPU,  1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 21'h000401, 1'b0, 1'b1, O_VID,  1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 21'h000402, 1'b1, 1'b1, O_DMA,  1'b1};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 21'h000403, 1'b1, 1'b0, O_CPU,  1'b1};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 21'h000404, 1'b1, 1'b0, O_DMA,  1'b1};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 21'h000405, 1'b0, 1'b1, O_IDLE, 1'b1};
        tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 21'h000406, 1'b1, 1'b1, O_VID,  1'b0};

        set_ph();
        repeat (3) step();
        chk("rst_dram_req", dram_req, 1'b0);
        chk("rst_dram_rnw", dram_rnw, 1'b1);
        chk("rst_dram_bsel", dram_bsel, 2'b00);
        chk("rst_dram_addr", dram_addr, 21'h0);
        chk("rst_dram_wrdata", dram_wrdata, 16'h0);
        chk("rst_cpu_rddata", cpu_rddata, 16'h0);
        chk("rst_cpu_latch", cpu_latch, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            do_cycle(tbl[i].v, tbl[i].c, tbl[i].crnw, tbl[i].cbs, tbl[i].cb, tbl[i].caddr,
                     tbl[i].d, tbl[i].drnw, tbl[i].eown, tbl[i].enext, 16'hBEEF);

        // Video holds off the CPU for three cycles, CPU wins as soon as video drops.
        for (int i = 0; i < 3; i++)
            do_cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h0, 21'h000050, 1'b0, 1'b1, O_VID, 1'b0, 16'h1111);
        do_cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h0, 21'h000051, 1'b0, 1'b1, O_CPU, 1'b1, 16'h2222);
        do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h0, 21'h0, 1'b0, 1'b1, O_IDLE, 1'b1, 16'h0);

        // Back-to-back CPU reads keep the latch high between strobes.
        do_cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h0, 21'h000010, 1'b0, 1'b1, O_CPU, 1'b1, 16'h1234);
        do_cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h0, 21'h000011, 1'b0, 1'b1, O_CPU, 1'b1, 16'h5678);
        do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h0, 21'h0, 1'b0, 1'b1, O_IDLE, 1'b1, 16'h0);

        // CPU and DMA both held: DMA only gets in after LIM losses when the guard is built.
        for (int i = 0; i < 9; i++) begin
            eo = (guard_on && (i % 5 == 4)) ? O_DMA : O_CPU;
            do_cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h0, 21'(i), 1'b1, 1'b1, eo,
                     !(guard_on && (i % 5 == 4)), 16'(i));
        end
        do_cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h0, 21'h60, 1'b1, 1'b1, O_VID, 1'b0, 16'h6060);
        do_cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h0, 21'h61, 1'b1, 1'b1,
                 guard_on ? O_DMA : O_CPU, !guard_on, 16'h6161);
        do_cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h0, 21'h0, 1'b0, 1'b1, O_IDLE, 1'b1, 16'h0);

        // Reset asserted at c1 of a CPU read aborts the cycle.
        to_c3();
        vid_req = 0; dma_req = 0; cpu_req = 1; cpu_rnw = 1; cpu_addr = 21'h000777;
        step();
        chk("abort_granted", dram_req, 1'b1);
        cpu_req = 0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_dram_req", dram_req, 1'b0);
        chk("abort_dram_addr", dram_addr, 21'h0);
        chk("abort_dram_rnw", dram_rnw, 1'b1);
        chk("abort_dram_bsel", dram_bsel, 2'b00);
        chk("abort_cpu_rddata", cpu_rddata, 16'h0);
        chk("abort_latch", cpu_latch, 1'b0);
        step();
        dram_rddata = 16'hDEAD;
        #1;
        chk("abort_cpu_strobe", cpu_strobe, 1'b0);
        step();
        rst_n = 1'b1;
        losses = 0; prev_rd = 1'b0; rd_hold = 16'h0;
        do_cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h0, 21'h000321, 1'b0, 1'b1, O_CPU, 1'b1, 16'hC0DE);

        // Randomized traffic against the priority/starvation rules.
        for (int i = 0; i < 150; i++) begin
            v = ($urandom_range(0, 3) == 0);
            c = 1'($urandom);
            d = 1'($urandom);
            urg = guard_on && (losses == LIM);
            if (v)             eo = O_VID;
            else if (urg && d) eo = O_DMA;
            else if (c)        eo = O_CPU;
            else if (d)        eo = O_DMA;
            else               eo = O_IDLE;
            do_cycle(v, c, 1'($urandom), 1'($urandom), 8'($urandom), 21'($urandom), d,
                     1'($urandom), eo, !v && !(urg && d), 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

- Shares one 16-bit DRAM port between three requesters: video fetch, Z80 memory manager and DMA.
- Picks one owner per 4-phase DRAM cycle (c0..c3).
- Drives the DRAM controller's address and command inputs.
- Returns per-requester handshakes: `*_next`, `*_strobe` and `cpu_latch`, plus held read data for the CPU path.

## Interface
Parameters:
- `STARVE_LIM`, default 4: number of consecutive lost arbitrations after which DMA is promoted above CPU.

Ports:
- `clk` in 1: system clock (28 MHz); all phases are one-`clk` pulses.
- `rst_n` in 1: asynchronous, active-low reset.
- `c0`, `c1`, `c2`, `c3` in 1 each: phase strobes, one-hot, repeating c0→c1→c2→c3.
- `vid_req` in 1: video wants the next DRAM cycle.
- `vid_addr` in 21: video word address.
- `vid_next` out 1: video owns the next cycle.
- `vid_strobe` out 1: video read data valid on `dram_rddata`.
- `cpu_req` in 1: CPU request.
- `cpu_rnw` in 1: 1 = read, 0 = write.
- `cpu_addr` in 21: CPU word address.
- `cpu_wrbsel` in 1: byte select for CPU writes.
- `cpu_wrdata` in 8: CPU write byte.
- `cpu_next` out 1: a CPU request sampled at this c3 will be granted.
- `cpu_strobe` out 1: one-`clk` pulse when CPU read data is valid.
- `cpu_latch` out 1: `cpu_rddata` holds fresh data.
- `cpu_rddata` out 16: held CPU read word.
- `dma_req` in 1: DMA request.
- `dma_rnw` in 1: 1 = read, 0 = write.
- `dma_addr` in 21: DMA word address.
- `dma_wrdata` in 16: DMA write word.
- `dma_next` out 1: DMA owns the next cycle.
- `dma_strobe` out 1: DMA read data valid / write accepted.
- `dram_req` out 1: DRAM controller cycle enable.
- `dram_rnw` out 1: DRAM read/write.
- `dram_addr` out 21: DRAM word address.
- `dram_bsel` out 2: byte enables, [1] = high byte.
- `dram_wrdata` out 16: DRAM write word.
- `dram_rddata` in 16: DRAM read data, valid at c2 of the owning cycle.

## Operation
- Owner state register `own` ∈ {IDLE, VID, CPU, DMA}; updated only on c3, held through the following c0..c3.
- Grant rule at c3, in priority order:
  - `vid_req` → VID.
  - else `dma_urgent && dma_req` → DMA.
  - else `cpu_req` → CPU.
  - else `dma_req` → DMA.
  - else IDLE.
- `dma_urgent` = starvation counter == `STARVE_LIM`. Counter behaviour:
  - increments (saturating) at each c3 where `dma_req` is high and DMA is not granted;
  - clears on a DMA grant or when `dma_req` is low at c3.
- `cpu_next` (combinational) = `!vid_req && !(dma_urgent && dma_req)`. `vid_next` and `dma_next` are combinational previews of the same decision.
- DRAM outputs are registered at c3 from the winner:
  - CPU write: `dram_bsel` = `cpu_wrbsel ? 2'b10 : 2'b01`; `dram_wrdata` = {`cpu_wrdata`, `cpu_wrdata`}.
  - All other cycles: `dram_bsel` = 2'b11.
  - `dram_req` = (`own` != IDLE).
- Strobes are driven at c2 of the owning cycle:
  - `vid_strobe` = c2 && VID.
  - `cpu_strobe` = c2 && CPU && read.
  - `dma_strobe` = c2 && DMA, for both read and write.
- CPU read data: on `cpu_strobe`, capture `dram_rddata` into `cpu_rddata`. `cpu_latch` goes high the `clk` after `cpu_strobe` and falls on the next c2 unless that c2 is another CPU read strobe.
- A granted cycle always completes; requester inputs are not resampled after c3.

## Timing
- Reset values:
  - `own` = IDLE; starvation counter 0.
  - All strobes, `cpu_latch` and `dram_req` = 0; `dram_rnw` = 1; `dram_bsel` = 0.
  - `dram_addr`, `dram_wrdata` and `cpu_rddata` = 0.
- Read latency: request sampled at c3 → data on `*_strobe` at c2 of the next cycle, i.e. 3 `clk` later.
- Boundary cases:
  - Request arriving on any phase other than c3 waits for the next c3.
  - Requester dropping `*_req` after its grant: its cycle still runs.
  - `rst_n` low mid-cycle: outputs clear immediately; no strobe fires for the aborted cycle.
  - Simultaneous `vid_req`, `cpu_req` and `dma_req` with `dma_urgent`: VID wins and the DMA counter stays saturated.

## Configuration
- `DRAM_ARB_STARVE_GUARD_EN` defined: the starvation counter and `dma_urgent` promotion are implemented as described.
- Not defined: strict priority VID > CPU > DMA; `dma_urgent` tied to 0, no counter logic; `cpu_next` = `!vid_req`.

## Test plan
- Idle bus, CPU read at 0x012345 asserted before c3 → `dram_addr`=0x012345 and `dram_rnw`=1 after c3; `cpu_strobe` at next c2; `cpu_rddata` = `dram_rddata` (0xBEEF); `cpu_latch` high for 4 `clk`.
- CPU write with `cpu_wrbsel`=1, data 0xA5 → `dram_bsel`=2'b10, `dram_wrdata`=0xA5A5, `dram_rnw`=0, no `cpu_strobe`.
- `vid_req` and `cpu_req` both held for 3 cycles → 3 VID grants, `cpu_next`=0 throughout; CPU granted on the first c3 after `vid_req` falls.
- With guard enabled and `STARVE_LIM`=4, `cpu_req` and `dma_req` held → 4 CPU cycles, then 1 DMA cycle, then the pattern repeats. With the macro undefined, DMA is never granted.
- Assert `rst_n` low at c1 of a CPU read → no `cpu_strobe`; all outputs at reset values. Operation resumes normally at the first c3 after release.
- Back-to-back CPU reads (0x000010, then 0x000011) → two `cpu_strobe` pulses 4 `clk` apart; `cpu_latch` stays continuously high across both.
